// File: rtl/raster_streamer.sv
// Streams a stored IMG_W x IMG_H frame from a sync-read RAM in raster order,
// tagging sof/eol/eof, through a 2-entry skid FIFO with valid/ready handshake.
module raster_streamer #(
  parameter int IMG_W  = 15,
  parameter int IMG_H  = 15,
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        freq_flag_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  data_out,
  output logic              valid,
  input  logic              ready,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic [2:0]        freq_flag,
  output logic              busy,
  output logic              done
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NPIX - 1);
  localparam logic [CW-1:0]     LAST_C = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     LAST_R = RW'(IMG_H - 1);

  generate
    if (NPIX > (1 << ADDR_W)) begin : g_size_chk
      $error("raster_streamer: IMG_W*IMG_H exceeds RAM address space");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } tag_t;
  typedef struct packed {
    logic [PIX_W-1:0] data;
    tag_t             tag;
  } beat_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              rd_vld;
  tag_t              rd_tag;
  beat_t             fifo_q [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt;
  logic [2:0]        occ;
  logic              issue, push, pop;
  beat_t             head;

  assign head  = fifo_q[rd_ptr];
  assign valid = (cnt != 2'd0);
  assign pop   = valid && ready;
  assign push  = rd_vld;

  // A beat leaving this cycle frees its slot, so reads keep flowing at full rate.
  assign occ   = {1'b0, cnt} + {2'b0, rd_vld} - {2'b0, pop};
  assign issue = (state == S_STREAM) && (occ < 3'd2);

  assign mem_ren  = issue;
  assign mem_addr = rd_cnt;
  assign data_out = head.data;
  assign sof      = valid && head.tag.sof;
  assign eol      = valid && head.tag.eol;
  assign eof      = valid && head.tag.eof;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_STREAM;
      S_STREAM: if (issue && rd_cnt == LAST_A) state_nxt = S_DRAIN;
      S_DRAIN:  if (pop && head.tag.eof) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      freq_flag <= '0;
      rd_cnt    <= '0;
      col       <= '0;
      row       <= '0;
      rd_vld    <= 1'b0;
      rd_tag    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      cnt       <= '0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        freq_flag <= freq_flag_in;
        rd_cnt    <= '0;
        col       <= '0;
        row       <= '0;
      end else if (issue) begin
        if (rd_cnt != LAST_A) rd_cnt <= rd_cnt + 1'b1;
        if (col == LAST_C) begin
          col <= '0;
          row <= (row == LAST_R) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // Tags travel alongside the read so they line up with the returning data.
      rd_vld <= issue;
      if (issue) begin
        rd_tag.sof <= (rd_cnt == '0);
        rd_tag.eol <= (col == LAST_C);
        rd_tag.eof <= (row == LAST_R) && (col == LAST_C);
      end
      if (push) begin
        fifo_q[wr_ptr] <= '{data: mem_rdata, tag: rd_tag};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule
